// File: rtl/main_fifo_ctrl_if.sv
// FIFO-side signal bundle between the main transmit FIFO, the four VC FIFOs and main_fifo_ctrl.
// master = controller side, slave = FIFO side.
interface main_fifo_ctrl_if #(
  parameter int CLASS_MSB = 5
);
  logic                 main_empty;
  logic                 main_full;
  logic                 main_almost_full;
  logic                 main_error;
  logic [CLASS_MSB:0]   main_data;
  logic [3:0]           vc_almost_full;
  logic [3:0]           vc_empty;
  logic [3:0]           vc_error;
  logic                 fifo_init;
  logic                 main_rd_enable;
  logic [3:0]           vc_push;

  modport master (
    input  main_empty, main_full, main_almost_full, main_error, main_data,
    input  vc_almost_full, vc_empty, vc_error,
    output fifo_init, main_rd_enable, vc_push
  );

  modport slave (
    output main_empty, main_full, main_almost_full, main_error, main_data,
    output vc_almost_full, vc_empty, vc_error,
    input  fifo_init, main_rd_enable, vc_push
  );
endinterface

// File: rtl/main_fifo_ctrl.sv
// Main transmit FIFO controller: bring-up sequencing, threshold latching,
// pop scheduling into the four VC FIFOs and upstream pause.
//
// state  | meaning
// RESET  | just out of reset, FIFOs held cleared
// INIT   | FIFOs held cleared, thresholds tracking their inputs
// IDLE   | running, waiting for main FIFO data
// ACTIVE | popping main FIFO into VC FIFOs
// ERROR  | sticky fault, all traffic stopped until reset
module main_fifo_ctrl #(
  parameter int CLASS_MSB = 5,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_main_in,
  input  logic [3:0]            umbral_vc_in,
  main_fifo_ctrl_if.master      fifo,
  output logic [3:0]            umbral_main,
  output logic [3:0]            umbral_vc,
  output logic                  pause,
  output logic [2:0]            state,
  output logic                  idle,
  output logic                  error_out,
  output logic [CNT_W-1:0]      words_popped
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        umbral_main_q, umbral_main_d;
  logic [3:0]        umbral_vc_q, umbral_vc_d;
  logic [CNT_W-1:0]  words_popped_q, words_popped_d;
  logic              rd_d1_q, rd_d1_d;

  logic              err_cond;
  logic              rd_en;
  logic              all_empty;
  logic [1:0]        word_class;

  assign err_cond   = fifo.main_error | (|fifo.vc_error);
  assign all_empty  = fifo.main_empty & (&fifo.vc_empty);
  assign word_class = fifo.main_data[CLASS_MSB -: 2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RESET;
      umbral_main_q  <= '0;
      umbral_vc_q    <= '0;
      words_popped_q <= '0;
      rd_d1_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      umbral_main_q  <= umbral_main_d;
      umbral_vc_q    <= umbral_vc_d;
      words_popped_q <= words_popped_d;
      rd_d1_q        <= rd_d1_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    umbral_main_d  = umbral_main_q;
    umbral_vc_d    = umbral_vc_q;
    words_popped_d = words_popped_q;
    rd_en          = 1'b0;
    fifo.fifo_init = 1'b0;
    idle           = 1'b0;
    error_out      = 1'b0;
    pause          = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        umbral_main_d  = umbral_main_in;
        umbral_vc_d    = umbral_vc_in;
        words_popped_d = '0;
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        fifo.fifo_init = 1'b1;
        pause          = fifo.main_almost_full | fifo.main_full;
        idle           = all_empty;
        if (err_cond)             state_d = ST_ERROR;
        else if (init)            state_d = ST_INIT;
        else if (!fifo.main_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        fifo.fifo_init = 1'b1;
        pause          = fifo.main_almost_full | fifo.main_full;
        // Any VC near full stalls every read, whatever class sits at the head.
        rd_en          = !fifo.main_empty && !(|fifo.vc_almost_full) && !err_cond;
        if (err_cond)                   state_d = ST_ERROR;
        else if (all_empty && !rd_d1_q) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        fifo.fifo_init = 1'b1;
        pause          = fifo.main_almost_full | fifo.main_full;
        error_out      = 1'b1;
      end
      default: state_d = ST_RESET;
    endcase

    if (rd_en) words_popped_d = words_popped_q + 1'b1;
    rd_d1_d = rd_en;
  end

  // The word read last cycle is on main_data now; drop it if a fault is present.
  always_comb begin
    fifo.vc_push = 4'b0000;
    if (rd_d1_q && (state_q != ST_ERROR) && !err_cond)
      fifo.vc_push = 4'b0001 << word_class;
  end

  assign fifo.main_rd_enable = rd_en;
  assign umbral_main         = umbral_main_q;
  assign umbral_vc           = umbral_vc_q;
  assign words_popped        = words_popped_q;
  assign state               = state_q;

endmodule

// File: tb/tb_main_fifo_ctrl.sv
// Self-checking bench for main_fifo_ctrl: bring-up vector table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_main_fifo_ctrl;

  logic        clk;
  logic        reset;
  logic        init;
  logic [3:0]  umbral_main_in, umbral_vc_in;
  logic [3:0]  umbral_main, umbral_vc;
  logic        pause;
  logic [2:0]  state;
  logic        idle;
  logic        error_out;
  logic [7:0]  words_popped;

  main_fifo_ctrl_if #(.CLASS_MSB(5)) bus ();

  main_fifo_ctrl #(.CLASS_MSB(5), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_main_in (umbral_main_in),
    .umbral_vc_in   (umbral_vc_in),
    .fifo           (bus.master),
    .umbral_main    (umbral_main),
    .umbral_vc      (umbral_vc),
    .pause          (pause),
    .state          (state),
    .idle           (idle),
    .error_out      (error_out),
    .words_popped   (words_popped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;

  // Environment: main FIFO contents and push scoreboard
  logic [5:0] q[$];
  logic [1:0] exp_cls[$];
  logic [3:0] got[$];

  // Reference model
  int         m_st;
  logic       m_rd_d1;
  logic [1:0] m_cls;
  logic [7:0] m_wp;
  logic [3:0] m_um, m_uv;

  typedef struct {
    logic       init;
    logic [3:0] um_in;
    logic [3:0] uv_in;
    logic [2:0] st;
    logic       fi;
    logic [3:0] um;
    logic [3:0] uv;
    logic       idl;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_rd_d1 = 1'b0; m_cls = 2'd0; m_wp = 8'd0; m_um = 4'd0; m_uv = 4'd0;
  endtask

  task automatic add_word(input logic [1:0] c);
    q.push_back({c, 4'($urandom)});
    exp_cls.push_back(c);
    bus.main_empty = 1'b0;
  endtask

  // Called at posedge+1; compares mid-cycle, then advances the model.
  task automatic check_phase();
    logic err, e_rd, e_pause, e_idle;
    logic [3:0] e_push;
    int n_st;
    #3;
    err     = bus.main_error | (|bus.vc_error);
    e_rd    = (m_st == 3) && !bus.main_empty && (bus.vc_almost_full == 4'h0) && !err;
    e_push  = (m_rd_d1 && m_st != 4 && !err) ? (4'b0001 << m_cls) : 4'b0000;
    e_pause = (m_st >= 2) && (bus.main_almost_full | bus.main_full);
    e_idle  = (m_st == 2) && bus.main_empty && (bus.vc_empty == 4'hF);
    chk("state", state, m_st);
    chk("fifo_init", bus.fifo_init, m_st >= 2);
    chk("rd_enable", bus.main_rd_enable, e_rd);
    chk("vc_push", bus.vc_push, e_push);
    chk("pause", pause, e_pause);
    chk("idle", idle, e_idle);
    chk("error_out", error_out, m_st == 4);
    chk("umbral_main", umbral_main, m_um);
    chk("umbral_vc", umbral_vc, m_uv);
    chk("words_popped", words_popped, m_wp);
    if (bus.main_rd_enable) rd_cnt++;
    if (bus.vc_push != 4'h0) got.push_back(bus.vc_push);
    n_st = m_st;
    case (m_st)
      0: n_st = 1;
      1: begin
        m_um = umbral_main_in; m_uv = umbral_vc_in; m_wp = 8'd0;
        if (!init) n_st = 2;
      end
      2: if (err) n_st = 4; else if (init) n_st = 1; else if (!bus.main_empty) n_st = 3;
      3: if (err) n_st = 4;
         else if (bus.main_empty && bus.vc_empty == 4'hF && !m_rd_d1) n_st = 2;
      default: ;
    endcase
    if (e_rd) begin
      m_wp = m_wp + 8'd1;
      if (q.size() > 0) m_cls = q[0][5:4];
    end
    m_rd_d1 = e_rd;
    m_st = n_st;
  endtask

  task automatic advance();
    logic [5:0] w;
    logic have;
    have = 1'b0; w = '0;
    if (bus.main_rd_enable && q.size() > 0) begin
      w = q.pop_front();
      have = 1'b1;
    end
    @(posedge clk); #1;
    if (have) bus.main_data = w;
    bus.main_empty = (q.size() == 0);
  endtask

  task automatic tick();
    check_phase();
    advance();
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (state != 3'(s) && n < budget) begin
      tick();
      n++;
    end
    if (state != 3'(s)) begin
      failures++;
      checks++;
      $display("FAIL timeout_%s actual=%0d required=%0d", name, state, s);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    tick();
    while (!(state == 3'd2 && q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(state == 3'd2 && q.size() == 0)) begin
      failures++;
      $display("FAIL drain_%s actual_state=%0d left=%0d required_state=2", name, state, q.size());
    end
  endtask

  task automatic cmp_sb(input string name);
    chk({name, "_push_count"}, got.size(), exp_cls.size());
    for (int i = 0; i < got.size() && i < exp_cls.size(); i++)
      chk({name, "_push_order"}, got[i], 4'b0001 << exp_cls[i]);
    got.delete();
    exp_cls.delete();
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd1, 4'd2, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 4'd1, 4'd2, 3'd1, 1'b0, 4'd0, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 4'd1, 4'd2, 3'd1, 1'b0, 4'd1, 4'd2, 1'b0};
    tbl[3] = '{1'b0, 4'd1, 4'd2, 3'd1, 1'b0, 4'd1, 4'd2, 1'b0};
    tbl[4] = '{1'b0, 4'd7, 4'd9, 3'd2, 1'b1, 4'd1, 4'd2, 1'b1};
    tbl[5] = '{1'b0, 4'd7, 4'd9, 3'd2, 1'b1, 4'd1, 4'd2, 1'b1};

    reset = 1'b0; init = 1'b1; umbral_main_in = 4'd1; umbral_vc_in = 4'd2;
    bus.main_empty = 1'b1; bus.main_full = 1'b0; bus.main_almost_full = 1'b0;
    bus.main_error = 1'b0; bus.main_data = '0; bus.vc_almost_full = 4'h0;
    bus.vc_empty = 4'hF; bus.vc_error = 4'h0;
    model_reset();
    #1;
    chk("rst_state", state, 0);
    chk("rst_fifo_init", bus.fifo_init, 0);
    chk("rst_words", words_popped, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Bring-up table
    for (int i = 0; i < 6; i++) begin
      init = tbl[i].init; umbral_main_in = tbl[i].um_in; umbral_vc_in = tbl[i].uv_in;
      check_phase();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_fifo_init", i), bus.fifo_init, tbl[i].fi);
      chk($sformatf("tbl%0d_umbral_main", i), umbral_main, tbl[i].um);
      chk($sformatf("tbl%0d_umbral_vc", i), umbral_vc, tbl[i].uv);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].idl);
      advance();
    end

    // Three words, classes 2, 0, 3
    rd_cnt = 0;
    add_word(2'd2); add_word(2'd0); add_word(2'd3);
    drain(20, "three");
    chk("three_rd_cycles", rd_cnt, 3);
    chk("three_words", words_popped, 3);
    chk("three_idle", idle, 1);
    cmp_sb("three");

    // VC almost-full stall for 4 cycles
    for (int i = 0; i < 6; i++) add_word(2'($urandom_range(0, 3)));
    wait_state(3, 10, "active_b");
    tick();
    bus.vc_almost_full = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      check_phase();
      chk("stall_rd", bus.main_rd_enable, 0);
      advance();
    end
    bus.vc_almost_full = 4'h0;
    check_phase();
    chk("resume_rd", bus.main_rd_enable, 1);
    advance();
    drain(30, "stall");
    cmp_sb("stall");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) add_word(2'($urandom_range(0, 3)));
      bus.vc_almost_full = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      bus.main_full = 1'($urandom);
      bus.main_almost_full = 1'($urandom);
      bus.vc_empty = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick();
    end
    bus.vc_almost_full = 4'h0; bus.vc_empty = 4'hF;
    bus.main_full = 1'b0; bus.main_almost_full = 1'b0;
    drain(300, "random");
    cmp_sb("random");

    // Counter wrap and init deferred while ACTIVE
    init = 1'b1; umbral_main_in = 4'd5; umbral_vc_in = 4'd6;
    wait_state(1, 5, "reinit");
    init = 1'b0;
    wait_state(2, 5, "reidle");
    chk("reinit_words", words_popped, 0);
    for (int i = 0; i < 257; i++) add_word(2'($urandom_range(0, 3)));
    for (int i = 0; i < 20; i++) tick();
    init = 1'b1;
    wait_state(2, 400, "wrap_idle");
    chk("wrap_words", words_popped, 1);
    tick();
    chk("init_in_idle_state", state, 1);
    tick();
    chk("init_clear_words", words_popped, 0);
    init = 1'b0;
    wait_state(2, 5, "wrap_back");
    cmp_sb("wrap");

    // Error during a read burst
    for (int i = 0; i < 5; i++) add_word(2'($urandom_range(0, 3)));
    wait_state(3, 10, "active_err");
    tick();
    bus.main_error = 1'b1;
    check_phase();
    chk("err_rd_blocked", bus.main_rd_enable, 0);
    chk("err_push_dropped", bus.vc_push, 0);
    advance();
    bus.main_error = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("err_sticky_state", state, 4);
    chk("err_sticky_out", error_out, 1);
    got.delete(); exp_cls.delete();

    // Asynchronous reset mid-ACTIVE
    reset = 1'b0;
    model_reset();
    q.delete();
    bus.main_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    init = 1'b1; umbral_main_in = 4'd3; umbral_vc_in = 4'd4;
    wait_state(1, 5, "rst2_init");
    tick();
    init = 1'b0;
    wait_state(2, 5, "rst2_idle");
    for (int i = 0; i < 4; i++) add_word(2'($urandom_range(0, 3)));
    bus.main_full = 1'b1;
    wait_state(3, 10, "rst2_active");
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_rd", bus.main_rd_enable, 0);
    chk("async_push", bus.vc_push, 0);
    chk("async_fifo_init", bus.fifo_init, 0);
    chk("async_pause", pause, 0);
    chk("async_umbral_main", umbral_main, 0);
    chk("async_umbral_vc", umbral_vc, 0);
    chk("async_words", words_popped, 0);
    chk("async_error_out", error_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
